// File: rtl/laser_packet_rx.sv
`default_nettype none
// ============================================================================
//  Module   : laser_packet_rx
//  Purpose  : Optical-link frame receiver. Oversamples a photodiode line,
//             recovers one start bit, PKT_LENGTH data bits (LSB first) and
//             one stop bit, and publishes each correctly framed payload with a
//             one-cycle new_data strobe. Bad stop bits raise frame_err.
//  Revision : 1.0 - initial release
// ============================================================================
module laser_packet_rx #(
  parameter int CLK_PER_BIT = 13540,
  parameter int PKT_LENGTH  = 288
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  output logic [PKT_LENGTH-1:0] data,
  output logic                  new_data,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam int IDX_W = $clog2(PKT_LENGTH + 1);

  // Counter compare points: mid start bit, then one full bit period apart.
  localparam logic [CNT_W-1:0] C_HALF_M1   = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] C_FULL_M1   = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(PKT_LENGTH - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] C_IDX_ONE   = IDX_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              sync_q, sync_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [PKT_LENGTH-1:0]   shift_q, shift_d;
  logic [PKT_LENGTH-1:0]   data_q, data_d;
  logic                    new_data_q, new_data_d;
  logic                    frame_err_q, frame_err_d;
  logic                    rxs;

  // Two-flop synchronizer; rx is asynchronous to clk and idles high.
  assign sync_d = {sync_q[0], rx};
  assign rxs    = sync_q[1];

  // Register bank: all state, including synchronizer presets, under async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      new_data_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      new_data_q  <= new_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state, bit timing and payload capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    new_data_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == C_HALF_M1) begin
          cnt_d = '0;
          if (!rxs) begin
            idx_d   = '0;
            state_d = DATA;
          end else begin
            // Line went back high before mid start bit: a glitch, not a frame.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_q == C_FULL_M1) begin
          cnt_d = '0;
          // Decoded write keeps the index width independent of PKT_LENGTH.
          for (int i = 0; i < PKT_LENGTH; i++) begin
            if (idx_q == IDX_W'(i)) begin
              shift_d[i] = rxs;
            end
          end
          if (idx_q == C_LAST_IDX) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + C_IDX_ONE;
          end
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      STOP: begin
        if (cnt_q == C_FULL_M1) begin
          cnt_d = '0;
          if (rxs) begin
            data_d     = shift_q;
            new_data_d = 1'b1;
            state_d    = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      WAIT_IDLE: begin
        cnt_d = '0;
        // A line stuck low must not be mistaken for a new start bit.
        if (rxs) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign data      = data_q;
  assign new_data  = new_data_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_laser_packet_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_laser_packet_rx
//  Purpose  : Directed self-checking bench for laser_packet_rx. A small
//             instance (8 cycles/bit, 8-bit payload) covers the frame cases;
//             a wide instance (288-bit payload) covers the full payload width.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_laser_packet_rx;

  localparam int CPB     = 8;
  localparam int N       = 8;
  localparam int CPB_BIG = 16;
  localparam int N_BIG   = 288;

  // Cycles from the edge after rx falls to the negedge showing new_data:
  // 2 synchronizer + 1 idle detect + CPB/2 to mid start + CPB*(N+1) to stop.
  localparam int LAT_SMALL = 79;    // 3 + 4 + 8*9
  localparam int LAT_BIG   = 4635;  // 3 + 8 + 16*289

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rx;
  logic              rx_big;
  logic [N-1:0]      data;
  logic              new_data, frame_err, busy;
  logic [N_BIG-1:0]  data_big;
  logic              new_data_big, frame_err_big, busy_big;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int nd_pulses = 0, fe_pulses = 0, both_cnt = 0, nd_cyc = 0;
  int nd_big = 0, fe_big = 0, nd_big_cyc = 0;
  int frame_start = 0;

  logic [N_BIG-1:0] pat_big;

  laser_packet_rx #(.CLK_PER_BIT(CPB), .PKT_LENGTH(N)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .data(data), .new_data(new_data), .frame_err(frame_err), .busy(busy)
  );

  laser_packet_rx #(.CLK_PER_BIT(CPB_BIG), .PKT_LENGTH(N_BIG)) dut_big (
    .clk(clk), .rst_n(rst_n), .rx(rx_big),
    .data(data_big), .new_data(new_data_big), .frame_err(frame_err_big), .busy(busy_big)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: counts high cycles so a stretched pulse shows up as extra.
  always @(negedge clk) begin
    if (new_data) begin nd_pulses++; nd_cyc = cyc; end
    if (frame_err) fe_pulses++;
    if (new_data && frame_err) both_cnt++;
    if (new_data_big) begin nd_big++; nd_big_cyc = cyc; end
    if (frame_err_big) fe_big++;
  end

  // All frame tasks start and end 1 ns after a rising edge.
  task automatic hold_line(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] v, input logic stop_bit);
    frame_start = cyc;
    hold_line(1'b0, CPB);
    for (int i = 0; i < N; i++) hold_line(v[i], CPB);
    hold_line(stop_bit, CPB);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++; if (new_data !== 1'b0) begin failures++; $display("FAIL reset_new_data got=%b exp=0", new_data); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (data_big !== '0) begin failures++; $display("FAIL reset_data_big nonzero"); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    hold_line(1'b1, 5);
  endtask

  task automatic test_good_frame;
    int nd0, fe0;
    nd0 = nd_pulses; fe0 = fe_pulses;
    send_frame(8'hA5, 1'b1);
    hold_line(1'b1, 20);
    @(negedge clk);
    checks++; if (data !== 8'hA5) begin failures++; $display("FAIL good_data got=%h exp=a5", data); end
    checks++; if (nd_pulses - nd0 != 1) begin failures++; $display("FAIL good_new_data_cycles got=%0d exp=1", nd_pulses - nd0); end
    checks++; if (fe_pulses - fe0 != 0) begin failures++; $display("FAIL good_frame_err got=%0d exp=0", fe_pulses - fe0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL good_busy_after got=%b exp=0", busy); end
    checks++; if (nd_cyc - frame_start != LAT_SMALL) begin failures++; $display("FAIL good_latency got=%0d exp=%0d", nd_cyc - frame_start, LAT_SMALL); end
    @(posedge clk); #1;
  endtask

  task automatic test_glitch;
    int nd0, fe0;
    nd0 = nd_pulses; fe0 = fe_pulses;
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL glitch_enters_start got=%b exp=1", busy); end
    hold_line(1'b1, 20);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_after got=%b exp=0", busy); end
    checks++; if (nd_pulses - nd0 != 0) begin failures++; $display("FAIL glitch_new_data got=%0d exp=0", nd_pulses - nd0); end
    checks++; if (fe_pulses - fe0 != 0) begin failures++; $display("FAIL glitch_frame_err got=%0d exp=0", fe_pulses - fe0); end
    checks++; if (data !== 8'hA5) begin failures++; $display("FAIL glitch_data got=%h exp=a5", data); end
    @(posedge clk); #1;
  endtask

  task automatic test_bad_stop;
    int nd0, fe0;
    nd0 = nd_pulses; fe0 = fe_pulses;
    send_frame(8'h3C, 1'b0);
    hold_line(1'b0, 40);
    @(negedge clk);
    checks++; if (fe_pulses - fe0 != 1) begin failures++; $display("FAIL badstop_frame_err got=%0d exp=1", fe_pulses - fe0); end
    checks++; if (nd_pulses - nd0 != 0) begin failures++; $display("FAIL badstop_new_data got=%0d exp=0", nd_pulses - nd0); end
    checks++; if (data !== 8'hA5) begin failures++; $display("FAIL badstop_data got=%h exp=a5", data); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL badstop_wait_idle_busy got=%b exp=1", busy); end
    @(posedge clk); #1;
    hold_line(1'b1, 20);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL badstop_busy_after got=%b exp=0", busy); end
    checks++; if (fe_pulses - fe0 != 1) begin failures++; $display("FAIL badstop_no_restart got=%0d exp=1", fe_pulses - fe0); end
    checks++; if (nd_pulses - nd0 != 0) begin failures++; $display("FAIL badstop_no_frame got=%0d exp=0", nd_pulses - nd0); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int nd0, fe0;
    nd0 = nd_pulses; fe0 = fe_pulses;
    send_frame(8'h01, 1'b1);
    checks++; if (data !== 8'h01) begin failures++; $display("FAIL b2b_first_data got=%h exp=01", data); end
    checks++; if (nd_pulses - nd0 != 1) begin failures++; $display("FAIL b2b_first_pulse got=%0d exp=1", nd_pulses - nd0); end
    send_frame(8'hFF, 1'b1);
    hold_line(1'b1, 20);
    @(negedge clk);
    checks++; if (data !== 8'hFF) begin failures++; $display("FAIL b2b_second_data got=%h exp=ff", data); end
    checks++; if (nd_pulses - nd0 != 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", nd_pulses - nd0); end
    checks++; if (fe_pulses - fe0 != 0) begin failures++; $display("FAIL b2b_frame_err got=%0d exp=0", fe_pulses - fe0); end
    checks++; if (nd_cyc - frame_start != LAT_SMALL) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=%0d", nd_cyc - frame_start, LAT_SMALL); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_frame;
    int nd0, fe0;
    logic [7:0] v;
    v = 8'h77;
    nd0 = nd_pulses; fe0 = fe_pulses;
    hold_line(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold_line(v[i], CPB);
    hold_line(v[4], CPB / 2);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%h exp=00", data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    hold_line(1'b1, 20);
    checks++; if (nd_pulses - nd0 != 0) begin failures++; $display("FAIL rstmid_no_strobe got=%0d exp=0", nd_pulses - nd0); end
    send_frame(8'h5A, 1'b1);
    hold_line(1'b1, 20);
    @(negedge clk);
    checks++; if (data !== 8'h5A) begin failures++; $display("FAIL rstmid_data_after got=%h exp=5a", data); end
    checks++; if (nd_pulses - nd0 != 1) begin failures++; $display("FAIL rstmid_pulses got=%0d exp=1", nd_pulses - nd0); end
    checks++; if (fe_pulses - fe0 != 0) begin failures++; $display("FAIL rstmid_frame_err got=%0d exp=0", fe_pulses - fe0); end
    @(posedge clk); #1;
  endtask

  task automatic test_wide_payload;
    int start;
    for (int w = 0; w < N_BIG / 32; w++)
      pat_big[32*w +: 32] = 32'h1357_9BDF ^ (32'h0101_0101 * (w + 1));
    start = cyc;
    rx_big = 1'b0;
    repeat (CPB_BIG) @(posedge clk);
    #1;
    for (int i = 0; i < N_BIG; i++) begin
      rx_big = pat_big[i];
      repeat (CPB_BIG) @(posedge clk);
      #1;
    end
    rx_big = 1'b1;
    repeat (CPB_BIG + 20) @(posedge clk);
    @(negedge clk);
    checks++; if (data_big !== pat_big) begin failures++; $display("FAIL wide_data got=%h exp=%h", data_big[63:0], pat_big[63:0]); end
    checks++; if (nd_big != 1) begin failures++; $display("FAIL wide_new_data got=%0d exp=1", nd_big); end
    checks++; if (fe_big != 0) begin failures++; $display("FAIL wide_frame_err got=%0d exp=0", fe_big); end
    checks++; if (busy_big !== 1'b0) begin failures++; $display("FAIL wide_busy got=%b exp=0", busy_big); end
    checks++; if (nd_big_cyc - start != LAT_BIG) begin failures++; $display("FAIL wide_latency got=%0d exp=%0d", nd_big_cyc - start, LAT_BIG); end
  endtask

  initial begin
    rst_n  = 1'b0;
    rx     = 1'b1;
    rx_big = 1'b1;
    repeat (3) @(posedge clk);
    test_reset;
    test_good_frame;
    test_glitch;
    test_bad_stop;
    test_back_to_back;
    test_reset_mid_frame;
    test_wide_payload;
    checks++; if (both_cnt != 0) begin failures++; $display("FAIL strobe_overlap got=%0d exp=0", both_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
